// File: rtl/door_lock_ctrl.sv
// Keypad door lock sequencer: compares entered 8-bit codes against a
// programmable stored code, auto-relocks after a timeout and locks the
// keypad out for a fixed period after repeated failed attempts.
module door_lock_ctrl #(
   parameter logic [7:0]  CODE_RESET     = 8'b11011001,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned UNLOCK_CYCLES  = 500,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   localparam int unsigned FW            = $clog2(MAX_TRIES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    key,
   input  logic          key_valid,
   input  logic          prog_en,
   output logic          locked,
   output logic          unlocked,
   output logic          error,
   output logic          lockout,
   output logic          prog_done,
   output logic [FW-1:0] fail_cnt
);

   localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [FW:0]   MAX_T     = (FW + 1)'(MAX_TRIES);

   typedef enum logic [1:0] {
      S_LOCKED   = 2'd0,
      S_UNLOCKED = 2'd1,
      S_LOCKOUT  = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [7:0]    code, code_n;
   logic [FW-1:0] fail_n;
   logic [TW-1:0] timer, timer_n;
   logic          error_n, prog_done_n;
   logic [FW:0]   fail_inc;

   // One extra bit so the lockout compare cannot wrap.
   assign fail_inc = {1'b0, fail_cnt} + {{FW{1'b0}}, 1'b1};

   // State, code, counters and pulse flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_LOCKED;
         code      <= CODE_RESET;
         fail_cnt  <= '0;
         timer     <= '0;
         error     <= 1'b0;
         prog_done <= 1'b0;
      end else begin
         state     <= state_n;
         code      <= code_n;
         fail_cnt  <= fail_n;
         timer     <= timer_n;
         error     <= error_n;
         prog_done <= prog_done_n;
      end
   end

   // Next-state logic; key actions take priority over timer expiry.
   always_comb begin
      state_n     = state;
      code_n      = code;
      fail_n      = fail_cnt;
      timer_n     = timer;
      error_n     = 1'b0;
      prog_done_n = 1'b0;
      case (state)
         S_LOCKED: begin
            if (key_valid) begin
               if (key == code) begin
                  state_n = S_UNLOCKED;
                  timer_n = T_UNLOCK;
                  fail_n  = '0;
               end else begin
                  error_n = 1'b1;
                  if (fail_inc == MAX_T) begin
                     state_n = S_LOCKOUT;
                     timer_n = T_LOCKOUT;
                     fail_n  = '0;
                  end else begin
                     fail_n = fail_inc[FW-1:0];
                  end
               end
            end
         end
         S_UNLOCKED: begin
            if (key_valid && prog_en) begin
               code_n      = key;
               prog_done_n = 1'b1;
               timer_n     = T_UNLOCK;
            end else if (key_valid) begin
               state_n = S_LOCKED;
            end else if (timer == '0) begin
               state_n = S_LOCKED;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         S_LOCKOUT: begin
            if (key_valid) error_n = 1'b1;
            if (timer == '0) state_n = S_LOCKED;
            else             timer_n = timer - TW'(1);
         end
         default: state_n = S_LOCKED;
      endcase
   end

   // Status outputs decoded from the registered state only.
   always_comb begin
      locked   = (state == S_LOCKED) || (state == S_LOCKOUT);
      unlocked = (state == S_UNLOCKED);
      lockout  = (state == S_LOCKOUT);
   end

endmodule
